// File: rtl/periph_pkg.sv
// periph_pkg: shared register map and bit positions for the memory-mapped timer.
`default_nettype none

package periph_pkg;

  localparam logic [31:0] TIMER_BASE = 32'h4000_0000;

  localparam logic [3:0] TH_OFS   = 4'h0;
  localparam logic [3:0] TL_OFS   = 4'h4;
  localparam logic [3:0] TCON_OFS = 4'h8;
  localparam logic [3:0] TPS_OFS  = 4'hC;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

endpackage

`default_nettype wire

// File: rtl/timer_irq_if.sv
// timer_irq_if: data-memory bus view of the timer plus its interrupt line.
`default_nettype none

interface timer_irq_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  modport master (output addr, wdata, MemRead, MemWrite, input rdata, hit, irq);
  modport slave  (input addr, wdata, MemRead, MemWrite, output rdata, hit, irq);
endinterface

`default_nettype wire

// File: rtl/timer_prescaler.sv
// timer_prescaler: emits one tick every (tps+1) enabled cycles; held in reset while disabled.
`default_nettype none

module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] tps,
  output logic       tick
);

  logic [7:0] r_cnt;

  assign tick = en && (r_cnt == tps);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!en || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/timer_irq.sv
// timer_irq: 32-bit reload timer with level interrupt on the data-memory bus.
// Optional TPS prescaler register is built when TIMER_PRESCALE_EN is defined.
`default_nettype none

module timer_irq
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TIMER_BASE
) (
  input  logic        clk,
  input  logic        reset,
  timer_irq_if.slave  bus
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;

  logic        w_hit;
  logic [3:0]  w_ofs;
  logic        w_wr;
  logic        w_rd;
  logic        w_tick;
  logic        w_ovf;
  logic        w_st_set;
  logic        w_unused;

  assign w_hit    = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign w_ofs    = {bus.addr[3:2], 2'b00};
  assign w_wr     = bus.MemWrite && w_hit;
  assign w_rd     = bus.MemRead && w_hit;
  assign w_unused = ^bus.addr[1:0];

`ifdef TIMER_PRESCALE_EN
  logic [7:0] r_tps;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tps <= '0;
    end else if (w_wr && (w_ofs == TPS_OFS)) begin
      r_tps <= bus.wdata[7:0];
    end
  end

  timer_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (r_tcon[TCON_EN]),
    .tps   (r_tps),
    .tick  (w_tick)
  );
`else
  assign w_tick = r_tcon[TCON_EN];
`endif

  assign w_ovf    = w_tick && (r_tl == 32'hFFFF_FFFF);
  assign w_st_set = w_ovf && r_tcon[TCON_IE];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      if (w_wr && (w_ofs == TH_OFS)) begin
        r_th <= bus.wdata;
      end
      // A software TL write beats both the reload and the increment.
      if (w_wr && (w_ofs == TL_OFS)) begin
        r_tl <= bus.wdata;
      end else if (w_ovf) begin
        r_tl <= r_th;
      end else if (w_tick) begin
        r_tl <= r_tl + 32'd1;
      end
      // An overflow in the same cycle as a clearing write keeps ST set.
      if (w_wr && (w_ofs == TCON_OFS)) begin
        r_tcon <= {bus.wdata[TCON_ST] | w_st_set, bus.wdata[TCON_IE], bus.wdata[TCON_EN]};
      end else if (w_st_set) begin
        r_tcon[TCON_ST] <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (w_rd) begin
      case (w_ofs)
        TH_OFS:   bus.rdata = r_th;
        TL_OFS:   bus.rdata = r_tl;
        TCON_OFS: bus.rdata = {29'd0, r_tcon};
`ifdef TIMER_PRESCALE_EN
        TPS_OFS:  bus.rdata = {24'd0, r_tps};
`endif
        default:  bus.rdata = '0;
      endcase
    end
  end

  assign bus.hit = w_hit;
  assign bus.irq = r_tcon[TCON_ST];

endmodule

`default_nettype wire

// File: tb/tb_timer_irq.sv
// tb_timer_irq: directed spec scenarios plus randomized bus traffic against a reference model.
`default_nettype none

module tb_timer_irq;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic clk = 1'b0;
  logic reset;
  timer_irq_if bus ();

  timer_irq #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: register contents and cycles elapsed since the last prescale tick.
  logic [31:0] m_th, m_tl;
  logic [2:0]  m_tcon;
  logic [7:0]  m_tps;
  int          m_since;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_th = '0; m_tl = '0; m_tcon = '0; m_tps = '0; m_since = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic rd);
    if (!rd || a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd0: return m_th;
      2'd1: return m_tl;
      2'd2: return {29'd0, m_tcon};
`ifdef TIMER_PRESCALE_EN
      default: return {24'd0, m_tps};
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  // Check outputs for the current inputs, clock once, advance the model.
  task automatic step();
    logic        en, tick, ovf, wr, hit;
    logic [1:0]  idx;
    logic [31:0] nth, ntl;
    logic [2:0]  ntcon;
    #1;
    hit = (bus.addr[31:4] == BASE[31:4]);
    check("hit", {31'd0, bus.hit}, {31'd0, hit});
    check("irq", {31'd0, bus.irq}, {31'd0, m_tcon[2]});
    check("rdata", bus.rdata, model_read(bus.addr, bus.MemRead));
    en  = m_tcon[0];
    wr  = bus.MemWrite && hit;
    idx = bus.addr[3:2];
`ifdef TIMER_PRESCALE_EN
    tick = en && (m_since == int'(m_tps));
`else
    tick = en;
`endif
    ovf   = tick && (m_tl == 32'hFFFF_FFFF);
    nth   = (wr && idx == 2'd0) ? bus.wdata : m_th;
    ntl   = (wr && idx == 2'd1) ? bus.wdata : ovf ? m_th : tick ? m_tl + 1 : m_tl;
    ntcon = (wr && idx == 2'd2) ? bus.wdata[2:0] : m_tcon;
    if (ovf && m_tcon[1]) ntcon[2] = 1'b1;
`ifdef TIMER_PRESCALE_EN
    if (wr && idx == 2'd3) m_tps = bus.wdata[7:0];
`endif
    m_since = (!en || tick) ? 0 : m_since + 1;
    @(posedge clk);
    m_th = nth; m_tl = ntl; m_tcon = ntcon;
    #1;
  endtask

  task automatic wr(input logic [3:0] ofs, input logic [31:0] data, input logic rd);
    bus.addr = BASE + {28'd0, ofs}; bus.wdata = data;
    bus.MemWrite = 1'b1; bus.MemRead = rd;
    step();
    bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
  endtask

  task automatic idle();
    bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
    step();
  endtask

  task automatic rd_expect(input string tag, input logic [3:0] ofs, input logic [31:0] exp);
    bus.addr = BASE + {28'd0, ofs}; bus.MemRead = 1'b1; bus.MemWrite = 1'b0;
    #1;
    check(tag, bus.rdata, exp);
    bus.MemRead = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.addr = '0; bus.wdata = '0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rd_expect("rst_tcon", 4'h8, 32'd0);
    check("rst_irq", {31'd0, bus.irq}, 32'd0);

    // Reload with interrupt enabled.
    wr(4'h0, 32'hFFFF_FFFC, 1'b0);
    wr(4'h4, 32'hFFFF_FFFE, 1'b0);
    wr(4'h8, 32'd3, 1'b0);
    rd_expect("tl_start", 4'h4, 32'hFFFF_FFFE);
    idle();
    rd_expect("tl_edge1", 4'h4, 32'hFFFF_FFFF);
    check("irq_prewrap", {31'd0, bus.irq}, 32'd0);
    idle();
    rd_expect("tl_reload", 4'h4, 32'hFFFF_FFFC);
    check("irq_wrap", {31'd0, bus.irq}, 32'd1);

    // Software clear, then clear attempted in the overflow cycle.
    wr(4'h8, 32'd3, 1'b0);
    check("irq_clear", {31'd0, bus.irq}, 32'd0);
    idle(); idle();
    rd_expect("tl_ff", 4'h4, 32'hFFFF_FFFF);
    wr(4'h8, 32'd3, 1'b0);
    check("irq_kept", {31'd0, bus.irq}, 32'd1);
    rd_expect("tcon_7", 4'h8, 32'd7);

    // TL write in overflow cycle wins; TH write in reload cycle is not used.
    wr(4'h8, 32'd3, 1'b0);
    idle(); idle();
    wr(4'h4, 32'd5, 1'b0);
    rd_expect("tl_wr_wins", 4'h4, 32'd5);
    rd_expect("tcon_st_set", 4'h8, 32'd7);
    wr(4'h4, 32'hFFFF_FFFE, 1'b0);
    idle();
    bus.addr = BASE; bus.wdata = 32'd9; bus.MemWrite = 1'b1; bus.MemRead = 1'b1;
    #1 check("rd_during_wr", bus.rdata, 32'hFFFF_FFFC);
    step();
    bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
    rd_expect("tl_old_th", 4'h4, 32'hFFFF_FFFC);
    rd_expect("th_new", 4'h0, 32'd9);

    // Asynchronous reset mid-cycle with irq pending.
    #1 reset = 1'b1;
    #1;
    check("arst_irq", {31'd0, bus.irq}, 32'd0);
    rd_expect("arst_th", 4'h0, 32'd0);
    rd_expect("arst_tl", 4'h4, 32'd0);
    rd_expect("arst_tcon", 4'h8, 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;

    // Masked overflow.
    wr(4'h0, 32'hFFFF_FFFC, 1'b0);
    wr(4'h4, 32'hFFFF_FFFE, 1'b0);
    wr(4'h8, 32'd1, 1'b0);
    idle(); idle();
    rd_expect("mask_tl", 4'h4, 32'hFFFF_FFFC);
    rd_expect("mask_tcon", 4'h8, 32'd1);
    check("mask_irq", {31'd0, bus.irq}, 32'd0);
    wr(4'h8, 32'd0, 1'b0);

`ifdef TIMER_PRESCALE_EN
    wr(4'hC, 32'd3, 1'b0);
    wr(4'h4, 32'd0, 1'b0);
    wr(4'h8, 32'd1, 1'b0);
    repeat (4) idle();
    rd_expect("ps_tl1", 4'h4, 32'd1);
    repeat (4) idle();
    rd_expect("ps_tl2", 4'h4, 32'd2);
    rd_expect("ps_tps", 4'hC, 32'd3);
    wr(4'h8, 32'd0, 1'b0);
`else
    rd_expect("ofs_c_unmapped", 4'hC, 32'd0);
`endif

    // Randomized traffic, biased toward wraps.
    for (int i = 0; i < 600; i++) begin
      logic [1:0] idx;
      idx = 2'($urandom_range(0, 3));
      bus.addr = BASE + {28'd0, idx, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) bus.addr = $urandom();
      bus.MemRead  = 1'($urandom_range(0, 1));
      bus.MemWrite = ($urandom_range(0, 3) == 0);
      case (idx)
        2'd1:    bus.wdata = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        2'd2:    bus.wdata = ($urandom() & 32'hFFFF_FFF6) | 32'($urandom_range(0, 4) != 0);
        2'd3:    bus.wdata = 32'($urandom_range(0, 3));
        default: bus.wdata = ($urandom_range(0, 1) != 0) ? $urandom() : 32'hFFFF_FFF8;
      endcase
      step();
    end
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
